lcd_cmd_scheduler: RTL

- Queues 31-bit LCD draw commands from the CPU bus and issues them one at a time to the LCD engine's LCD_CRTL/LCDcrtl_en inputs.
- Sits between the APB/AHB LCD register slave and the LCD top.
- Holds all issue until panel initialisation has finished.
- Waits for each command's run-finish before issuing the next, with a timeout and sticky error flags.

---
 rtl/lcd_cmd_scheduler.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/lcd_cmd_scheduler.sv
// ---------------------------------------------------------------------------
// lcd_cmd_scheduler
// Buffers 31-bit LCD draw commands written by the CPU and hands them to the
// LCD engine one at a time. No command is issued until the panel init
// sequencer reports ready. After each issue the block waits for the engine's
// run-finish edge (or a timeout), then idles for GAP cycles before the next.
//
// Ports:
//   i_clk         system clock
//   i_rst         synchronous reset, active-high
//   i_push        enqueue request, i_cmd_in sampled when high
//   i_cmd_in      command word (opaque LCD_CRTL format)
//   i_ini_finish  panel ready level from the init sequencer
//   i_run_finish  engine finish, rising edge marks command complete
//   i_err_clr     one-cycle pulse clearing both sticky error flags
//   o_lcd_crtl    command presented to the engine, held until next issue
//   o_lcd_en      one-cycle issue strobe
//   o_full        FIFO holds 2**AW entries
//   o_empty       FIFO holds no entries
//   o_level       FIFO occupancy
//   o_busy        a command is in flight or the post-completion gap runs
//   o_ovf_err     sticky, a push was dropped at full
//   o_tmo_err     sticky, a command was abandoned on timeout
// ---------------------------------------------------------------------------
module lcd_cmd_scheduler #(
  parameter int AW      = 3,
  parameter int TIMEOUT = 1048576,
  parameter int GAP     = 2
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_push,
  input  logic [30:0]   i_cmd_in,
  input  logic          i_ini_finish,
  input  logic          i_run_finish,
  input  logic          i_err_clr,
  output logic [30:0]   o_lcd_crtl,
  output logic          o_lcd_en,
  output logic          o_full,
  output logic          o_empty,
  output logic [AW:0]   o_level,
  output logic          o_busy,
  output logic          o_ovf_err,
  output logic          o_tmo_err
);

  localparam int DEPTH = 1 << AW;
  localparam int TW    = $clog2(TIMEOUT + 1);
  localparam int GW    = $clog2(GAP + 1);

  typedef enum logic [2:0] {
    S_WAIT_INI,
    S_IDLE,
    S_ISSUE,
    S_WAIT_DONE,
    S_GAP
  } state_t;

  state_t          r_state;
  state_t          w_next;

  logic [30:0]     r_mem [DEPTH];
  logic [AW-1:0]   r_wptr;
  logic [AW-1:0]   r_rptr;
  logic [AW:0]     r_level;
  logic [30:0]     r_lcd_crtl;
  logic            r_lcd_en;
  logic            r_ovf_err;
  logic            r_tmo_err;
  logic [TW-1:0]   r_tmo_cnt;
  logic [GW-1:0]   r_gap_cnt;
  logic            r_run_finish_d;

  logic            w_done;
  logic            w_full;
  logic            w_empty;
  logic            w_pop;
  logic            w_tmo_hit;
  logic            w_push_ok;
  logic            w_drop;

  assign w_done    = i_run_finish & ~r_run_finish_d;
  assign w_empty   = (r_level == '0);
  assign w_full    = (r_level == (AW+1)'(DEPTH));
  // A push at full is still taken when the head leaves in the same cycle.
  assign w_push_ok = i_push & (~w_full | w_pop);
  assign w_drop    = i_push & w_full & ~w_pop;

  // Next-state logic. The pop happens on the IDLE->ISSUE transition so the
  // head word is latched into o_lcd_crtl together with the strobe. A done
  // edge wins over a timeout landing in the same cycle.
  always_comb begin
    w_next    = r_state;
    w_pop     = 1'b0;
    w_tmo_hit = 1'b0;
    case (r_state)
      S_WAIT_INI: begin
        if (i_ini_finish) w_next = S_IDLE;
      end
      S_IDLE: begin
        if (!i_ini_finish) begin
          w_next = S_WAIT_INI;
        end else if (!w_empty) begin
          w_pop  = 1'b1;
          w_next = S_ISSUE;
        end
      end
      S_ISSUE: begin
        w_next = S_WAIT_DONE;
      end
      S_WAIT_DONE: begin
        if (w_done) begin
          w_next = S_GAP;
        end else if (r_tmo_cnt == TW'(TIMEOUT - 1)) begin
          w_tmo_hit = 1'b1;
          w_next    = S_GAP;
        end
      end
      S_GAP: begin
        if (r_gap_cnt == GW'(GAP - 1)) w_next = S_IDLE;
      end
      default: w_next = S_WAIT_INI;
    endcase
  end

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= S_WAIT_INI;
    else       r_state <= w_next;
  end

  // FIFO storage has no reset; only the pointers define valid contents.
  always_ff @(posedge i_clk) begin
    if (w_push_ok) r_mem[r_wptr] <= i_cmd_in;
  end

  // FIFO pointers and occupancy. Push+pop together leaves the level alone.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else begin
      if (w_push_ok) r_wptr <= r_wptr + AW'(1);
      if (w_pop)     r_rptr <= r_rptr + AW'(1);
      case ({w_push_ok, w_pop})
        2'b10:   r_level <= r_level + (AW+1)'(1);
        2'b01:   r_level <= r_level - (AW+1)'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  // Issue strobe, command hold register, wait/gap counters and edge detect.
  // The timeout counter is zeroed in ISSUE so WAIT_DONE starts at 0; the gap
  // counter is held at 0 outside GAP so it always starts fresh.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_lcd_en       <= 1'b0;
      r_lcd_crtl     <= '0;
      r_tmo_cnt      <= '0;
      r_gap_cnt      <= '0;
      r_run_finish_d <= 1'b0;
    end else begin
      r_run_finish_d <= i_run_finish;
      r_lcd_en       <= w_pop;
      if (w_pop) r_lcd_crtl <= r_mem[r_rptr];
      if (r_state == S_ISSUE)          r_tmo_cnt <= '0;
      else if (r_state == S_WAIT_DONE) r_tmo_cnt <= r_tmo_cnt + TW'(1);
      if (r_state == S_GAP) r_gap_cnt <= r_gap_cnt + GW'(1);
      else                  r_gap_cnt <= '0;
    end
  end

  // Sticky error flags; a set in the same cycle as a clear wins.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_ovf_err <= 1'b0;
      r_tmo_err <= 1'b0;
    end else begin
      if (w_drop)         r_ovf_err <= 1'b1;
      else if (i_err_clr) r_ovf_err <= 1'b0;
      if (w_tmo_hit)      r_tmo_err <= 1'b1;
      else if (i_err_clr) r_tmo_err <= 1'b0;
    end
  end

  assign o_lcd_crtl = r_lcd_crtl;
  assign o_lcd_en   = r_lcd_en;
  assign o_full     = w_full;
  assign o_empty    = w_empty;
  assign o_level    = r_level;
  assign o_busy     = (r_state == S_ISSUE) || (r_state == S_WAIT_DONE) ||
                      (r_state == S_GAP);
  assign o_ovf_err  = r_ovf_err;
  assign o_tmo_err  = r_tmo_err;

endmodule
